// File: rtl/bpb_gshare.sv
// Branch prediction buffer: direct-mapped BTB plus a 2-bit counter PHT indexed
// either by PC (bimodal) or by PC XOR global history (gshare).
`ifndef BPB_E
`define BPB_E 16
`endif
`ifndef BPB_T
`define BPB_T 4
`endif

module bpb_gshare #(
    parameter int ENTRIES     = `BPB_E,
    parameter int INDEX_WIDTH = `BPB_T,
    parameter int GHR_WIDTH   = INDEX_WIDTH,
    parameter int MODE        = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] instr_addr_i,
    input  logic        is_branch_i,
    input  logic [31:0] update_pc_i,
    input  logic        real_taken_i,
    input  logic [31:0] real_addr_i,
    output logic        predict_taken_o,
    output logic [31:0] predict_addr_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispredict_cnt_o
);
    localparam int TAG_W = 32 - INDEX_WIDTH - 2;

    logic [ENTRIES-1:0]     valid;
    logic [TAG_W-1:0]       tag    [ENTRIES];
    logic [31:0]            target [ENTRIES];
    logic [1:0]             pht    [ENTRIES];
    logic [GHR_WIDTH-1:0]   ghr;
    logic [31:0]            branch_cnt;
    logic [31:0]            mispredict_cnt;

    logic [INDEX_WIDTH-1:0] ghr_ext;
    logic [INDEX_WIDTH-1:0] lk_idx, lk_pidx;
    logic                   lk_hit, lk_taken;
    logic [INDEX_WIDTH-1:0] up_idx, up_pidx;
    logic                   up_hit, up_taken, up_mispredict;
    logic [1:0]             up_ctr_next;
    logic                   write_en;
    logic                   unused_pc_bits;

    assign unused_pc_bits = ^{instr_addr_i[1:0], update_pc_i[1:0]};
    assign ghr_ext = INDEX_WIDTH'(ghr);

    // Fetch-side lookup, purely from registered state.
    always_comb begin
        lk_idx   = instr_addr_i[INDEX_WIDTH+1:2];
        lk_pidx  = (MODE == 1) ? (lk_idx ^ ghr_ext) : lk_idx;
        lk_hit   = valid[lk_idx] && (tag[lk_idx] == instr_addr_i[31:INDEX_WIDTH+2]);
        lk_taken = lk_hit && pht[lk_pidx][1];
    end

    assign predict_taken_o = lk_taken && !flush_i;
    assign predict_addr_o  = predict_taken_o ? target[lk_idx] : instr_addr_i + 32'd4;

    // The update port re-derives the prediction that was made for this branch.
    always_comb begin
        up_idx        = update_pc_i[INDEX_WIDTH+1:2];
        up_pidx       = (MODE == 1) ? (up_idx ^ ghr_ext) : up_idx;
        up_hit        = valid[up_idx] && (tag[up_idx] == update_pc_i[31:INDEX_WIDTH+2]);
        up_taken      = up_hit && pht[up_pidx][1];
        up_mispredict = (up_taken != real_taken_i) ||
                        (up_taken && (target[up_idx] != real_addr_i));
        up_ctr_next   = pht[up_pidx];
        if (real_taken_i && pht[up_pidx] != 2'b11)
            up_ctr_next = pht[up_pidx] + 2'd1;
        else if (!real_taken_i && pht[up_pidx] != 2'b00)
            up_ctr_next = pht[up_pidx] - 2'd1;
    end

    assign write_en = is_branch_i && !stall_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                pht[i]   <= 2'b01;
            end
            ghr            <= '0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (write_en) begin
            if (up_hit) begin
                pht[up_pidx] <= up_ctr_next;
                if (real_taken_i)
                    target[up_idx] <= real_addr_i;
            end else begin
                valid[up_idx]  <= 1'b1;
                tag[up_idx]    <= update_pc_i[31:INDEX_WIDTH+2];
                target[up_idx] <= real_addr_i;
                pht[up_pidx]   <= real_taken_i ? 2'b10 : 2'b01;
            end
            ghr            <= (MODE == 1) ? ((ghr << 1) | GHR_WIDTH'(real_taken_i)) : '0;
            branch_cnt     <= branch_cnt + 32'd1;
            mispredict_cnt <= mispredict_cnt + (up_mispredict ? 32'd1 : 32'd0);
        end
    end

    assign branch_cnt_o     = branch_cnt;
    assign mispredict_cnt_o = mispredict_cnt;

endmodule
